trng_sample_ctrl: RTL and testbench
===================================

// Module: trng_sample_ctrl
// PURPOSE
//   Sequencer between the TRNG entropy source and the AXI-Lite register bank.
//   Enables the source, discards warm-up samples, packs raw bits into words,
//   runs a repetition-count health test and buffers words in a small FIFO
//   that software pops through the register interface.
// PARAMETERS
//   WORD_W      32   bits per output word
//   FIFO_DEPTH  4    output FIFO entries, power of 2, >=2
//   WARMUP_CYC  64   cycles of discarded source output after enable
//   REP_LIMIT   16   identical consecutive bits that declare a health failure
// PORTS
//   sys_clk     in   1                  clock; all logic rising-edge
//   sys_reset   in   1                  synchronous, active-high reset
//   enable      in   1                  software enable (level)
//   clr_fail    in   1                  pulse; clears health_fail, FAIL->IDLE
//   raw_bit     in   1                  entropy bit, already synchronised
//   raw_valid   in   1                  raw_bit qualifier, one bit per cycle max
//   rd_req      in   1                  pop pulse from register read
//   osc_en      out  1                  entropy source enable
//   rd_data     out  WORD_W             FIFO head word
//   rd_valid    out  1                  FIFO non-empty
//   fifo_level  out  clog2(DEPTH)+1     entries held
//   health_fail out  1                  sticky health-test failure flag
//   busy        out  1                  state != IDLE
// BEHAVIOUR
//   Reset: state IDLE; osc_en, rd_valid, health_fail, busy = 0; fifo_level = 0;
//     rd_data = 0; shift reg, bit counter, run counter cleared.
//   All outputs registered; state changes visible one cycle after cause.
//   IDLE: osc_en=0. enable=1 -> WARMUP, warm-up counter loaded WARMUP_CYC.
//   WARMUP: osc_en=1; raw bits ignored; counter decrements per cycle; at 0
//     -> COLLECT; bit count=0, run count=0, last-bit cleared.
//   COLLECT: osc_en=1; per raw_valid: shreg <= {shreg[W-2:0],raw_bit} (first
//     bit lands at MSB); bit count++; WORD_W-th bit -> PUSH.
//   Health test in COLLECT: run=1 on first bit or bit change, else run+1;
//     run reaching REP_LIMIT -> FAIL, health_fail=1, partial word discarded.
//     Run count persists across word boundaries; it is not reset in PUSH.
//   PUSH: raw bits ignored. If fifo_level<DEPTH (registered value) write shreg,
//     -> COLLECT with bit count=0. If full: stay, osc_en=0 until space.
//   FAIL: osc_en=0; enable ignored; clr_fail -> IDLE, health_fail=0.
//   enable=0 in WARMUP/COLLECT/PUSH -> IDLE next cycle; partial word dropped;
//     FIFO contents retained and still readable.
//   FIFO: rd_data = head entry; rd_req with rd_valid=0 ignored, no underflow.
//     Simultaneous push and pop: level unchanged, both take effect. Pointers
//     wrap modulo DEPTH. Pop while full in PUSH frees slot; push next cycle.
//   clr_fail outside FAIL: no effect. sys_reset dominates every other input.
// TESTING
//   1 reset, enable=1, raw_valid=1 bits 1010..: osc_en=1 next cycle, 64 cycles
//     ignored, then 32 bits -> rd_data=32'hAAAAAAAA, rd_valid=1, level=1.
//   2 no reads, 5 words supplied -> level=4, osc_en=0 in PUSH; one rd_req
//     -> level 3 then 4 again, osc_en=1; pop order matches push order.
//   3 16 consecutive 1s in COLLECT -> health_fail=1, osc_en=0, no push;
//     enable toggling no effect; clr_fail -> health_fail=0, busy=0.
//   4 enable=0 after 10 bits, level=2 -> IDLE, level stays 2, no new word;
//     re-enable -> full WARMUP_CYC warm-up repeated.
//   5 rd_req on empty -> level 0, rd_valid 0; push+rd_req same cycle at
//     level 2 -> level 2, head advances.
//   6 sys_reset mid-COLLECT with level=3, health_fail=1 -> all outputs at
//     reset values next cycle; FIFO empty.

Source files
------------

// File: rtl/trng_sample_ctrl.sv
// trng_sample_ctrl: sequencer between the TRNG entropy source and the
// register bank. Enables the source, discards warm-up output, packs raw
// bits MSB-first into words, runs a repetition-count health test and
// buffers finished words in a small FIFO popped by register reads.
module trng_sample_ctrl #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int WARMUP_CYC = 64,
  parameter int REP_LIMIT  = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_reset,
  input  logic                          enable,
  input  logic                          clr_fail,
  input  logic                          raw_bit,
  input  logic                          raw_valid,
  input  logic                          rd_req,
  output logic                          osc_en,
  output logic [WORD_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail,
  output logic                          busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BCNT_W = $clog2(WORD_W + 1);
  localparam int RUN_W  = $clog2(REP_LIMIT + 1);
  localparam int WCNT_W = $clog2(WARMUP_CYC + 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_COLLECT,
    ST_PUSH,
    ST_FAIL
  } state_t;

  state_t              state, state_n;
  logic [WCNT_W-1:0]   warm_cnt, warm_n;
  logic [BCNT_W-1:0]   bit_cnt, bit_n;
  logic [RUN_W-1:0]    run_cnt, run_n, run_inc;
  logic                last_bit, last_n;
  logic                have_last, have_n;
  logic [WORD_W-1:0]   shreg, shreg_n;

  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0]    rd_ptr, rd_ptr_n;
  logic [LVL_W-1:0]    level, level_n;
  logic [WORD_W-1:0]   head_n;
  logic                push, pop;
  logic                fifo_full, fifo_empty;

  logic                osc_en_n, busy_n, health_fail_n;

  // FIFO occupancy flags from the registered level
  always_comb begin
    fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    fifo_empty = (level == '0);
  end

  // Sequencer: next state, warm-up countdown, bit packing and health test
  always_comb begin
    state_n = state;
    warm_n  = warm_cnt;
    bit_n   = bit_cnt;
    run_n   = run_cnt;
    last_n  = last_bit;
    have_n  = have_last;
    shreg_n = shreg;
    push    = 1'b0;
    run_inc = (have_last && (raw_bit == last_bit)) ? run_cnt + RUN_W'(1)
                                                   : RUN_W'(1);
    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          state_n = ST_WARMUP;
          warm_n  = WCNT_W'(WARMUP_CYC);
        end
      end
      ST_WARMUP: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else if (warm_cnt <= WCNT_W'(1)) begin
          state_n = ST_COLLECT;
          warm_n  = '0;
          bit_n   = '0;
          run_n   = '0;
          last_n  = 1'b0;
          have_n  = 1'b0;
        end else begin
          warm_n = warm_cnt - WCNT_W'(1);
        end
      end
      ST_COLLECT: begin
        if (!enable) begin
          state_n = ST_IDLE;
          bit_n   = '0;
        end else if (raw_valid) begin
          shreg_n = {shreg[WORD_W-2:0], raw_bit};
          run_n   = run_inc;
          last_n  = raw_bit;
          have_n  = 1'b1;
          // A failing bit wins over completing a word: the word is dropped.
          if (run_inc == RUN_W'(REP_LIMIT)) begin
            state_n = ST_FAIL;
            bit_n   = '0;
          end else if (bit_cnt == BCNT_W'(WORD_W - 1)) begin
            state_n = ST_PUSH;
            bit_n   = bit_cnt + BCNT_W'(1);
          end else begin
            bit_n = bit_cnt + BCNT_W'(1);
          end
        end
      end
      ST_PUSH: begin
        if (!enable) begin
          state_n = ST_IDLE;
          bit_n   = '0;
        end else if (!fifo_full) begin
          push    = 1'b1;
          state_n = ST_COLLECT;
          bit_n   = '0;
        end
      end
      ST_FAIL: begin
        if (clr_fail) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping and the head word that will be presented next cycle
  always_comb begin
    pop      = rd_req && !fifo_empty;
    level_n  = level + LVL_W'(push) - LVL_W'(pop);
    wr_ptr_n = wr_ptr + PTR_W'(push);
    rd_ptr_n = rd_ptr + PTR_W'(pop);
    // When the pushed word lands in an otherwise empty FIFO it becomes the
    // head directly, since the memory write is not yet visible.
    if (level_n == '0) begin
      head_n = '0;
    end else if (push && ((level - LVL_W'(pop)) == '0)) begin
      head_n = shreg;
    end else begin
      head_n = mem[rd_ptr_n];
    end
  end

  // Output values as they must appear after the coming edge
  always_comb begin
    osc_en_n      = (state_n == ST_WARMUP) || (state_n == ST_COLLECT) ||
                    ((state_n == ST_PUSH) && (level_n != LVL_W'(FIFO_DEPTH)));
    busy_n        = (state_n != ST_IDLE);
    health_fail_n = (state_n == ST_FAIL);
  end

  // State, counters, FIFO pointers and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state       <= ST_IDLE;
      warm_cnt    <= '0;
      bit_cnt     <= '0;
      run_cnt     <= '0;
      last_bit    <= 1'b0;
      have_last   <= 1'b0;
      shreg       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      osc_en      <= 1'b0;
      busy        <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      state       <= state_n;
      warm_cnt    <= warm_n;
      bit_cnt     <= bit_n;
      run_cnt     <= run_n;
      last_bit    <= last_n;
      have_last   <= have_n;
      shreg       <= shreg_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      level       <= level_n;
      rd_data     <= head_n;
      rd_valid    <= (level_n != '0);
      osc_en      <= osc_en_n;
      busy        <= busy_n;
      health_fail <= health_fail_n;
    end
  end

  // FIFO storage; contents need no reset because pointers and level do
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= shreg;
    end
  end

  assign fifo_level = level;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Bench for trng_sample_ctrl: a cycle-level behavioural model (queues of
// bits and words) is compared against every DUT output each cycle, and
// directed scenarios pin key values with hand-computed literals.
module tb_trng_sample_ctrl;

  localparam int DEPTH = 4;
  localparam int WARM  = 64;
  localparam int REP   = 16;

  localparam int M_IDLE = 0;
  localparam int M_WARM = 1;
  localparam int M_COLL = 2;
  localparam int M_PUSH = 3;
  localparam int M_FAIL = 4;

  logic        clk = 1'b0;
  logic        rst, en, cf, rb, rv, rr;
  logic        osc_en, rd_valid, health_fail, busy;
  logic [31:0] rd_data;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  trng_sample_ctrl #(
    .WORD_W     (32),
    .FIFO_DEPTH (DEPTH),
    .WARMUP_CYC (WARM),
    .REP_LIMIT  (REP)
  ) dut (
    .sys_clk     (clk),
    .sys_reset   (rst),
    .enable      (en),
    .clr_fail    (cf),
    .raw_bit     (rb),
    .raw_valid   (rv),
    .rd_req      (rr),
    .osc_en      (osc_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_level  (fifo_level),
    .health_fail (health_fail),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_mode = M_IDLE;
  int          m_warm = 0;
  int          m_run  = 0;
  bit          m_last = 1'b0;
  bit          m_have = 1'b0;
  bit          m_bits[$];
  logic [31:0] m_fifo[$];

  always @(posedge clk) begin : model
    logic [31:0] w;
    bit do_push, do_pop, was_full;
    do_push = 1'b0;
    w = '0;
    if (rst) begin
      m_mode = M_IDLE;
      m_warm = 0;
      m_run  = 0;
      m_last = 1'b0;
      m_have = 1'b0;
      m_bits.delete();
      m_fifo.delete();
    end else begin
      was_full = (m_fifo.size() == DEPTH);
      do_pop   = rr && (m_fifo.size() != 0);
      case (m_mode)
        M_IDLE: if (en) begin m_mode = M_WARM; m_warm = WARM; end
        M_WARM: begin
          if (!en) m_mode = M_IDLE;
          else begin
            m_warm--;
            if (m_warm == 0) begin
              m_mode = M_COLL; m_bits.delete(); m_run = 0; m_have = 1'b0;
            end
          end
        end
        M_COLL: begin
          if (!en) begin m_mode = M_IDLE; m_bits.delete(); end
          else if (rv) begin
            m_run  = (m_have && (rb == m_last)) ? m_run + 1 : 1;
            m_last = rb;
            m_have = 1'b1;
            m_bits.push_back(rb);
            if (m_run >= REP) begin m_mode = M_FAIL; m_bits.delete(); end
            else if (m_bits.size() == 32) m_mode = M_PUSH;
          end
        end
        M_PUSH: begin
          if (!en) begin m_mode = M_IDLE; m_bits.delete(); end
          else if (!was_full) begin
            foreach (m_bits[i]) w = {w[30:0], m_bits[i]};
            m_bits.delete();
            do_push = 1'b1;
            m_mode  = M_COLL;
          end
        end
        M_FAIL: if (cf) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
      if (do_pop)  void'(m_fifo.pop_front());
      if (do_push) m_fifo.push_back(w);
    end
  end

  function automatic logic exp_osc();
    return (m_mode == M_WARM) || (m_mode == M_COLL) ||
           ((m_mode == M_PUSH) && (m_fifo.size() < DEPTH));
  endfunction

  function automatic logic [31:0] exp_head();
    return (m_fifo.size() != 0) ? m_fifo[0] : 32'h0;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("osc_en",      32'(osc_en),      32'(exp_osc()));
      cmp("rd_valid",    32'(rd_valid),    32'(m_fifo.size() != 0));
      cmp("fifo_level",  32'(fifo_level),  32'(m_fifo.size()));
      cmp("rd_data",     rd_data,          exp_head());
      cmp("health_fail", 32'(health_fail), 32'(m_mode == M_FAIL));
      cmp("busy",        32'(busy),        32'(m_mode != M_IDLE));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic feed_word(input logic [31:0] w, input bit pop_on_push);
    for (int i = 31; i >= 0; i--) begin
      rv = 1'b1; rb = w[i]; tick(1);
    end
    rv = 1'b0; rr = pop_on_push; tick(1);
    rr = 1'b0;
  endtask

  task automatic feed_fail();
    rv = 1'b1; rb = 1'b0; tick(1);
    rb = 1'b1; tick(15);
    cmp("lit_hf_before_limit", 32'(health_fail), 32'd0);
    tick(1);
    rv = 1'b0;
    cmp("lit_hf_at_limit", 32'(health_fail), 32'd1);
    cmp("lit_osc_in_fail", 32'(osc_en), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, "_osc"},   32'(osc_en),      32'd0);
    cmp({tag, "_valid"}, 32'(rd_valid),    32'd0);
    cmp({tag, "_level"}, 32'(fifo_level),  32'd0);
    cmp({tag, "_data"},  rd_data,          32'd0);
    cmp({tag, "_hf"},    32'(health_fail), 32'd0);
    cmp({tag, "_busy"},  32'(busy),        32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cf = 1'b0; rb = 1'b0; rv = 1'b0; rr = 1'b0;
    tick(2);
    chk_en = 1'b1;
    check_reset_vals("lit_reset");
    rst = 1'b0;
    tick(1);
    cmp("lit_idle_osc", 32'(osc_en), 32'd0);

    // 1: warm-up discards 64 cycles of ones, then 1010.. packs to AAAAAAAA
    en = 1'b1; rv = 1'b1; rb = 1'b1;
    tick(1);
    cmp("lit_osc_after_en", 32'(osc_en), 32'd1);
    tick(WARM);
    for (int i = 0; i < 32; i++) begin
      rb = (i % 2 == 0); tick(1);
    end
    rv = 1'b0; tick(1);
    cmp("lit_first_word", rd_data, 32'hAAAAAAAA);
    cmp("lit_first_level", 32'(fifo_level), 32'd1);
    cmp("lit_first_valid", 32'(rd_valid), 32'd1);

    // 2: fill to full, stall in PUSH, pop frees a slot, drain in order
    feed_word(32'h12345678, 1'b0);
    feed_word(32'h9ABCDEF0, 1'b0);
    feed_word(32'h0F0F0F0F, 1'b0);
    feed_word(32'hC3C3C3C3, 1'b0);
    cmp("lit_full_level", 32'(fifo_level), 32'd4);
    cmp("lit_full_osc", 32'(osc_en), 32'd0);
    tick(3);
    rr = 1'b1; tick(1); rr = 1'b0;
    cmp("lit_pop_level", 32'(fifo_level), 32'd3);
    cmp("lit_pop_osc", 32'(osc_en), 32'd1);
    tick(1);
    cmp("lit_refill_level", 32'(fifo_level), 32'd4);
    cmp("lit_head1", rd_data, 32'h12345678);
    rr = 1'b1; tick(1);
    cmp("lit_head2", rd_data, 32'h9ABCDEF0);
    tick(1);
    cmp("lit_head3", rd_data, 32'h0F0F0F0F);
    tick(1);
    cmp("lit_head4", rd_data, 32'hC3C3C3C3);
    tick(1);
    cmp("lit_drained_level", 32'(fifo_level), 32'd0);

    // 5a: pop on empty is ignored
    tick(1); rr = 1'b0;
    cmp("lit_empty_level", 32'(fifo_level), 32'd0);
    cmp("lit_empty_valid", 32'(rd_valid), 32'd0);

    // 3: health failure, enable ignored in FAIL, clr_fail returns to IDLE
    feed_fail();
    cmp("lit_fail_level", 32'(fifo_level), 32'd0);
    en = 1'b0; tick(2); en = 1'b1; tick(2);
    cmp("lit_fail_sticky", 32'(health_fail), 32'd1);
    cmp("lit_fail_busy", 32'(busy), 32'd1);
    en = 1'b0; cf = 1'b1; tick(1); cf = 1'b0;
    cmp("lit_clr_hf", 32'(health_fail), 32'd0);
    cmp("lit_clr_busy", 32'(busy), 32'd0);
    cf = 1'b1; tick(1); cf = 1'b0; tick(1);

    // 4: disable mid-word keeps FIFO, re-enable repeats full warm-up
    en = 1'b1; rv = 1'b1; rb = 1'b1; tick(1 + WARM);
    feed_word(32'h01234567, 1'b0);
    feed_word(32'h89ABCDEF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      rv = 1'b1; rb = (i % 2 == 0); tick(1);
    end
    en = 1'b0; rv = 1'b0; tick(1);
    cmp("lit_dis_level", 32'(fifo_level), 32'd2);
    cmp("lit_dis_busy", 32'(busy), 32'd0);
    rv = 1'b1; rb = 1'b0; tick(3);
    cmp("lit_dis_nopush", 32'(fifo_level), 32'd2);
    en = 1'b1; rb = 1'b1; tick(1 + WARM);
    feed_word(32'h3CA53CA5, 1'b0);
    cmp("lit_rewarm_level", 32'(fifo_level), 32'd3);
    cmp("lit_rewarm_head", rd_data, 32'h01234567);

    // 5b: push and pop in the same cycle at level 2
    rr = 1'b1; tick(1); rr = 1'b0;
    cmp("lit_lvl2", 32'(fifo_level), 32'd2);
    feed_word(32'h6B6B6B6B, 1'b1);
    cmp("lit_pushpop_level", 32'(fifo_level), 32'd2);
    cmp("lit_pushpop_head", rd_data, 32'h3CA53CA5);

    // 6: reset with level 3 and a latched failure, then mid-COLLECT
    feed_word(32'hDEADBEEF, 1'b0);
    feed_fail();
    cmp("lit_pre_rst_level", 32'(fifo_level), 32'd3);
    rst = 1'b1; tick(1);
    check_reset_vals("lit_rst_fail");
    rst = 1'b0; tick(1);
    en = 1'b1; rv = 1'b1; rb = 1'b1; tick(1 + WARM);
    for (int i = 0; i < 5; i++) begin
      rb = (i % 2 == 0); tick(1);
    end
    rst = 1'b1; tick(1);
    check_reset_vals("lit_rst_coll");
    rst = 1'b0; en = 1'b0; rv = 1'b0; tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
